// File: rtl/shift_reg_n.sv
// Multi-mode WIDTH-bit register: hold/load/shift/rotate/arithmetic shift,
// plus a burst engine that repeats a latched shift/rotate a programmed number of steps.
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   reg_q, reg_d;
    logic               sout_q, sout_d;

    logic [2:0]         op_mode;
    logic [WIDTH-1:0]   step_val;
    logic               step_sout;
    logic               burst_ok;

    // One step of the selected operation; the latched mode drives it during a burst.
    always_comb begin
        op_mode   = (state_q == S_BUSY) ? mode_q : mode;
        step_val  = reg_q;
        step_sout = sout_q;
        case (op_mode)
            3'b001: step_val = d;
            3'b010: begin
                step_val  = {reg_q[WIDTH-2:0], sin};
                step_sout = reg_q[WIDTH-1];
            end
            3'b011: begin
                step_val  = {sin, reg_q[WIDTH-1:1]};
                step_sout = reg_q[0];
            end
            3'b100: begin
                step_val  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                step_sout = reg_q[WIDTH-1];
            end
            3'b101: begin
                step_val  = {reg_q[0], reg_q[WIDTH-1:1]};
                step_sout = reg_q[0];
            end
            3'b110: begin
                step_val  = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
                step_sout = reg_q[0];
            end
            default: ;
        endcase
    end

    assign burst_ok = (amt != '0) && (mode >= 3'b010) && (mode <= 3'b110);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    if (burst_ok) begin
                        state_d = S_BUSY;
                        cnt_d   = amt;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    reg_d  = step_val;
                    sout_d = step_sout;
                end
            end
            S_BUSY: begin
                reg_d  = step_val;
                sout_d = step_sout;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 3'b000;
            reg_q   <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
        end
    end

    assign q    = reg_q;
    assign qnot = ~reg_q;
    assign sout = sout_q;
    assign busy = (state_q == S_BUSY);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed checks of shift_reg_n (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_shift_reg_n;

    logic       clk;
    logic       clr;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic [7:0] qnot;
    logic       sout;
    logic       busy;
    logic       done;

    int err_cnt = 0;
    int chk_cnt = 0;

    shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .clr   (clr),
        .mode  (mode),
        .d     (d),
        .sin   (sin),
        .start (start),
        .amt   (amt),
        .q     (q),
        .qnot  (qnot),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " busy"}, 32'(busy), 32'(eb));
        check({tag, " done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        clr = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0; start = 1'b0; amt = 4'd0;
        #12;
        clr = 1'b1;
        tick();

        // 1. asynchronous reset between edges
        mode = 3'b001; d = 8'hA5; tick();
        check("pre-reset load", 32'(q), 32'hA5);
        mode = 3'b010; sin = 1'b0; tick();
        check("pre-reset shl q", 32'(q), 32'h4A);
        check("pre-reset shl sout", 32'(sout), 32'h1);
        mode = 3'b000;
        #2 clr = 1'b0;
        #1;
        check("reset q", 32'(q), 32'h00);
        check("reset qnot", 32'(qnot), 32'hFF);
        check("reset sout", 32'(sout), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        #3 clr = 1'b1;
        tick();

        // 2. direct operations
        mode = 3'b001; d = 8'h81; tick();
        check("load q", 32'(q), 32'h81);
        check("load qnot", 32'(qnot), 32'h7E);
        mode = 3'b010; sin = 1'b1; tick();
        check("shl q", 32'(q), 32'h03);
        check("shl sout", 32'(sout), 32'h1);
        mode = 3'b001; d = 8'h80; tick();
        mode = 3'b110; sin = 1'b1; tick();
        check("ashr q", 32'(q), 32'hC0);
        check("ashr sout", 32'(sout), 32'h0);
        mode = 3'b111; tick();
        check("rsvd hold q", 32'(q), 32'hC0);
        mode = 3'b000; d = 8'h55; tick();
        check("hold q", 32'(q), 32'hC0);

        // 3. rotate-left burst, mode changes ignored while busy
        mode = 3'b001; d = 8'h01; tick();
        mode = 3'b100; amt = 4'd3; start = 1'b1; tick();
        status("rotl k", 8'h01, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b001; d = 8'hEE; tick();
        status("rotl k+1", 8'h02, 1'b1, 1'b0);
        mode = 3'b011; tick();
        status("rotl k+2", 8'h04, 1'b1, 1'b0);
        tick();
        status("rotl k+3", 8'h08, 1'b0, 1'b1);
        check("rotl sout", 32'(sout), 32'h0);
        mode = 3'b001; d = 8'hFF; tick();
        status("rotl k+4", 8'h08, 1'b0, 1'b0);

        // 4. zero-length and invalid-mode bursts
        mode = 3'b010; amt = 4'd0; start = 1'b1; tick();
        status("amt0 k", 8'h08, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000; tick();
        status("amt0 k+1", 8'h08, 1'b0, 1'b0);
        mode = 3'b001; d = 8'hFF; amt = 4'd5; start = 1'b1; tick();
        status("badmode k", 8'h08, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000; tick();
        status("badmode k+1", 8'h08, 1'b0, 1'b0);

        // 5. wrap-around bursts
        mode = 3'b001; d = 8'hB4; tick();
        mode = 3'b101; amt = 4'd8; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000;
        for (int i = 1; i < 8; i++) tick();
        check("rotr8 busy before end", 32'(busy), 32'h1);
        tick();
        status("rotr8 end", 8'hB4, 1'b0, 1'b1);
        check("rotr8 sout", 32'(sout), 32'h1);
        tick();
        mode = 3'b011; sin = 1'b0; amt = 4'd9; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000; sin = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        status("shr9 end", 8'h00, 1'b0, 1'b1);
        check("shr9 sout", 32'(sout), 32'h0);
        tick();

        // 6. reset aborts a burst; the next start works normally
        mode = 3'b001; d = 8'h0F; tick();
        mode = 3'b010; sin = 1'b1; amt = 4'd6; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000; tick(); tick();
        status("abort step2", 8'h3F, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        status("abort during clr", 8'h00, 1'b0, 1'b0);
        #2 clr = 1'b1;
        tick();
        status("abort after 1", 8'h00, 1'b0, 1'b0);
        tick();
        status("abort after 2", 8'h00, 1'b0, 1'b0);
        mode = 3'b001; d = 8'h01; tick();
        mode = 3'b100; amt = 4'd1; start = 1'b1; tick();
        status("restart k", 8'h01, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000; tick();
        status("restart k+1", 8'h02, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
